// File: rtl/move_tick_gen.sv
// Move-rate tick generator: per-level frame prescaler, frame divider and wrapping step counter.
// Optional step limit with a done flag when MOVE_TICK_LIMIT_EN is defined.
module move_tick_gen #(
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned FRAME_W         = 4,
  parameter int unsigned FRAMES_PER_TICK = 2,
  parameter int unsigned PERIOD_L1       = 750000,
  parameter int unsigned PERIOD_L2       = 370000,
  parameter int unsigned PERIOD_L3       = 200000,
  parameter int unsigned STEP_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              pause,
  input  logic [1:0]        level,
`ifdef MOVE_TICK_LIMIT_EN
  input  logic [STEP_W-1:0] step_limit,
  output logic              done,
`endif
  output logic              frame_pulse,
  output logic              tick,
  output logic [STEP_W-1:0] step_count,
  output logic              active
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_e;

  state_e              state_q;
  logic [1:0]          lvl_q;
  logic [CNT_W-1:0]    delay_cnt_q;
  logic [FRAME_W-1:0]  frame_cnt_q;
  logic [STEP_W-1:0]   step_q;
  logic                frame_pulse_q;
  logic                tick_q;
  logic                active_q;

  logic [CNT_W-1:0]    period_m1_c;
  logic [CNT_W-1:0]    delay_cnt_d;
  logic [FRAME_W-1:0]  frame_cnt_d;
  logic [STEP_W-1:0]   step_d;
  logic                delay_last_c;
  logic                frame_last_c;
  logic                stop_c;
  logic                start_c;

`ifdef MOVE_TICK_LIMIT_EN
  logic done_q;
  logic limit_hit_c;
`endif

  // Terminal prescaler count for the latched level; level 0 never reaches RUN.
  always_comb begin
    period_m1_c = CNT_W'(PERIOD_L1 - 1);
    unique case (lvl_q)
      2'd2:    period_m1_c = CNT_W'(PERIOD_L2 - 1);
      2'd3:    period_m1_c = CNT_W'(PERIOD_L3 - 1);
      default: period_m1_c = CNT_W'(PERIOD_L1 - 1);
    endcase
  end

  assign delay_cnt_d  = delay_cnt_q + CNT_W'(1);
  assign frame_cnt_d  = frame_cnt_q + FRAME_W'(1);
  assign step_d       = step_q + STEP_W'(1);
  assign delay_last_c = (delay_cnt_q == period_m1_c);
  assign frame_last_c = (frame_cnt_q == FRAME_W'(FRAMES_PER_TICK - 1));
  assign stop_c       = !enable || (level == 2'd0);

`ifdef MOVE_TICK_LIMIT_EN
  assign limit_hit_c  = (step_limit != '0) && (step_d == step_limit);
  assign start_c      = enable && (level != 2'd0) && !done_q;
`else
  assign start_c      = enable && (level != 2'd0);
`endif

  // HOLD is entered/left purely from pause; a resume edge counts like any RUN edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      lvl_q         <= 2'd0;
      delay_cnt_q   <= '0;
      frame_cnt_q   <= '0;
      step_q        <= '0;
      frame_pulse_q <= 1'b0;
      tick_q        <= 1'b0;
      active_q      <= 1'b0;
`ifdef MOVE_TICK_LIMIT_EN
      done_q        <= 1'b0;
`endif
    end else begin
      frame_pulse_q <= 1'b0;
      tick_q        <= 1'b0;
      case (state_q)
        S_IDLE: begin
`ifdef MOVE_TICK_LIMIT_EN
          if (!enable) done_q <= 1'b0;
`endif
          if (start_c) begin
            state_q     <= S_RUN;
            lvl_q       <= level;
            delay_cnt_q <= '0;
            frame_cnt_q <= '0;
            step_q      <= '0;
            active_q    <= 1'b1;
          end
        end
        default: begin
          if (stop_c) begin
            state_q     <= S_IDLE;
            delay_cnt_q <= '0;
            frame_cnt_q <= '0;
            step_q      <= '0;
            active_q    <= 1'b0;
          end else begin
            state_q <= pause ? S_HOLD : S_RUN;
            if (level != lvl_q) begin
              lvl_q       <= level;
              delay_cnt_q <= '0;
              frame_cnt_q <= '0;
            end else if (!pause) begin
              if (delay_last_c) begin
                delay_cnt_q   <= '0;
                frame_pulse_q <= 1'b1;
                if (frame_last_c) begin
                  tick_q      <= 1'b1;
                  frame_cnt_q <= '0;
                  step_q      <= step_d;
`ifdef MOVE_TICK_LIMIT_EN
                  // Limit reached: finish in IDLE but keep the final step count visible.
                  if (limit_hit_c) begin
                    state_q  <= S_IDLE;
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                  end
`endif
                end else begin
                  frame_cnt_q <= frame_cnt_d;
                end
              end else begin
                delay_cnt_q <= delay_cnt_d;
              end
            end
          end
        end
      endcase
    end
  end

  assign frame_pulse = frame_pulse_q;
  assign tick        = tick_q;
  assign step_count  = step_q;
  assign active      = active_q;
`ifdef MOVE_TICK_LIMIT_EN
  assign done        = done_q;
`endif

endmodule

// File: tb/tb_move_tick_gen.sv
// Bench for move_tick_gen: hand vector table, directed corner sequences and random run vs an elapsed-cycle model.
module tb_move_tick_gen;
  localparam int unsigned P1 = 4, P2 = 3, P3 = 2, FPT = 2, SW = 4;

  logic          clk = 1'b0;
  logic          reset, enable, pause;
  logic [1:0]    level;
  logic          fp, tk, act;
  logic [SW-1:0] sc;
`ifdef MOVE_TICK_LIMIT_EN
  logic [SW-1:0] step_limit;
  logic          done;
`endif

  always #5 clk = ~clk;

  move_tick_gen #(
    .CNT_W(20), .FRAME_W(4), .FRAMES_PER_TICK(FPT),
    .PERIOD_L1(P1), .PERIOD_L2(P2), .PERIOD_L3(P3), .STEP_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pause(pause), .level(level),
`ifdef MOVE_TICK_LIMIT_EN
    .step_limit(step_limit), .done(done),
`endif
    .frame_pulse(fp), .tick(tk), .step_count(sc), .active(act)
  );

  int checks = 0;
  int errors = 0;

  // Model: count of counted edges since the last clear, ticks derived by modulo arithmetic.
  bit m_run, m_fp, m_tk;
  int m_lvl, m_n, m_steps;

  function automatic int per(input int l);
    return (l == 2) ? P2 : (l == 3) ? P3 : P1;
  endfunction

  task automatic model_edge();
    m_fp = 1'b0;
    m_tk = 1'b0;
    if (reset) begin
      m_run = 1'b0; m_n = 0; m_steps = 0; m_lvl = 0;
    end else if (!m_run) begin
      if (enable && level != 2'd0) begin
        m_run = 1'b1; m_lvl = int'(level); m_n = 0; m_steps = 0;
      end
    end else if (!enable || level == 2'd0) begin
      m_run = 1'b0; m_n = 0; m_steps = 0;
    end else if (int'(level) != m_lvl) begin
      m_lvl = int'(level); m_n = 0;
    end else if (!pause) begin
      m_n++;
      m_fp = (m_n % per(m_lvl)) == 0;
      m_tk = (m_n % (FPT * per(m_lvl))) == 0;
      if (m_tk) m_steps++;
    end
  endtask

  task automatic check1(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    check1({tag, " frame_pulse"}, int'(fp), int'(m_fp));
    check1({tag, " tick"}, int'(tk), int'(m_tk));
    check1({tag, " step_count"}, int'(sc), m_steps % (1 << SW));
    check1({tag, " active"}, int'(act), int'(m_run));
  endtask

  task automatic cyc(input bit en, input bit pa, input logic [1:0] lv);
    enable = en; pause = pa; level = lv;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Cycles until the next frame_pulse (want_tick=0) or tick (want_tick=1); -1 if the budget expires.
  task automatic cycles_to(input bit en, input bit pa, input logic [1:0] lv,
                           input bit want_tick, input int budget, output int c);
    c = -1;
    for (int i = 1; i <= budget && c < 0; i++) begin
      cyc(en, pa, lv);
      chk_model("seek");
      if ((want_tick ? tk : fp) == 1'b1) c = i;
    end
  endtask

  typedef struct {
    bit         en, pa;
    logic [1:0] lv;
    bit         fp, tk;
    int         st;
    bit         ac;
  } vec_t;

  function automatic vec_t mk(input bit en, input bit pa, input logic [1:0] lv,
                              input bit efp, input bit etk, input int est, input bit eac);
    vec_t v;
    v.en = en; v.pa = pa; v.lv = lv; v.fp = efp; v.tk = etk; v.st = est; v.ac = eac;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[16];
    int   c, c2, npulse, ntick, first_fp, s_before, tick_idx;
    logic [1:0] rl;

    vt[0]  = mk(1, 0, 2'd1, 0, 0, 0, 1);
    vt[1]  = mk(1, 0, 2'd1, 0, 0, 0, 1);
    vt[2]  = mk(1, 0, 2'd1, 0, 0, 0, 1);
    vt[3]  = mk(1, 0, 2'd1, 0, 0, 0, 1);
    vt[4]  = mk(1, 0, 2'd1, 1, 0, 0, 1);
    vt[5]  = mk(1, 0, 2'd1, 0, 0, 0, 1);
    vt[6]  = mk(1, 0, 2'd1, 0, 0, 0, 1);
    vt[7]  = mk(1, 0, 2'd1, 0, 0, 0, 1);
    vt[8]  = mk(1, 0, 2'd1, 1, 1, 1, 1);
    vt[9]  = mk(1, 0, 2'd1, 0, 0, 1, 1);
    vt[10] = mk(0, 0, 2'd1, 0, 0, 0, 0);
    vt[11] = mk(1, 0, 2'd3, 0, 0, 0, 1);
    vt[12] = mk(1, 0, 2'd3, 0, 0, 0, 1);
    vt[13] = mk(1, 0, 2'd3, 1, 0, 0, 1);
    vt[14] = mk(1, 0, 2'd3, 0, 0, 0, 1);
    vt[15] = mk(1, 0, 2'd3, 1, 1, 1, 1);

`ifdef MOVE_TICK_LIMIT_EN
    step_limit = '0;
`endif
    reset = 1'b1;
    cyc(0, 0, 2'd0);
    cyc(0, 0, 2'd0);
    check1("reset frame_pulse", int'(fp), 0);
    check1("reset tick", int'(tk), 0);
    check1("reset step_count", int'(sc), 0);
    check1("reset active", int'(act), 0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      cyc(vt[i].en, vt[i].pa, vt[i].lv);
      check1($sformatf("vec%0d frame_pulse", i), int'(fp), int'(vt[i].fp));
      check1($sformatf("vec%0d tick", i), int'(tk), int'(vt[i].tk));
      check1($sformatf("vec%0d step_count", i), int'(sc), vt[i].st);
      check1($sformatf("vec%0d active", i), int'(act), int'(vt[i].ac));
    end
    cyc(0, 0, 2'd0);
    chk_model("idle");

    // Basic rate at level 1
    cyc(1, 0, 2'd1);
    chk_model("t1 entry");
    npulse = 0; ntick = 0; first_fp = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1, 0, 2'd1);
      chk_model("t1");
      if (fp) begin
        npulse++;
        if (first_fp < 0) first_fp = i;
      end
      if (tk) ntick++;
    end
    check1("t1 first pulse cycle", first_fp, 4);
    check1("t1 pulse count", npulse, 10);
    check1("t1 tick count", ntick, 5);
    check1("t1 step_count", int'(sc), 5);

    // Pause mid-period delays the next pulse by the paused cycles
    cyc(1, 0, 2'd1); chk_model("t2 pre");
    cyc(1, 0, 2'd1); chk_model("t2 pre");
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 2'd1);
      chk_model("t2 paused");
      check1("t2 paused active", int'(act), 1);
    end
    cycles_to(1, 0, 2'd1, 1'b0, 10, c);
    check1("t2 resume to pulse", c, 2);

    // Level switch 1->3 mid-count
    cyc(1, 0, 2'd1); chk_model("t3 pre");
    s_before = int'(sc);
    cyc(1, 0, 2'd3);
    chk_model("t3 switch");
    check1("t3 switch no pulse", int'(fp), 0);
    cycles_to(1, 0, 2'd3, 1'b0, 10, c);
    check1("t3 switch to pulse", c, 2);
    check1("t3 step kept", int'(sc), s_before);
    cycles_to(1, 0, 2'd3, 1'b1, 10, c);
    cycles_to(1, 0, 2'd3, 1'b1, 10, c2);
    check1("t3 tick period", c2, 4);

    // Step counter wrap at level 3
    reset = 1'b1;
    cyc(0, 0, 2'd0);
    reset = 1'b0;
    cyc(1, 0, 2'd3);
    chk_model("t4 entry");
    for (int i = 1; i <= 68; i++) begin
      cyc(1, 0, 2'd3);
      chk_model("t4");
      if (i == 60) check1("t4 step before wrap", int'(sc), 15);
      if (i == 64) begin
        check1("t4 step wrapped", int'(sc), 0);
        check1("t4 wrap tick", int'(tk), 1);
      end
    end

    // Disable, then async reset mid-count
    cyc(0, 0, 2'd3);
    chk_model("t5 disable");
    check1("t5 disable active", int'(act), 0);
    check1("t5 disable step", int'(sc), 0);
    cyc(1, 0, 2'd1); chk_model("t5 entry");
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 2'd1);
      chk_model("t5 run");
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check1("t5 async frame_pulse", int'(fp), 0);
    check1("t5 async tick", int'(tk), 0);
    check1("t5 async step", int'(sc), 0);
    check1("t5 async active", int'(act), 0);
    cyc(1, 0, 2'd1);
    chk_model("t5 in reset");
    reset = 1'b0;
    cyc(1, 0, 2'd1);
    chk_model("t5 re-entry");
    cycles_to(1, 0, 2'd1, 1'b0, 10, c);
    check1("t5 first pulse after reset", c, 4);

    // Random stimulus against the model
    rl = 2'd1;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) rl = 2'($urandom_range(0, 3));
      cyc($urandom_range(0, 19) != 0, $urandom_range(0, 5) == 0, rl);
      chk_model("rand");
    end
    reset = 1'b0;

`ifdef MOVE_TICK_LIMIT_EN
    // Step limit: stop in IDLE at the third tick
    reset = 1'b1;
    cyc(0, 0, 2'd0);
    reset = 1'b0;
    step_limit = SW'(3);
    cyc(1, 0, 2'd2);
    ntick = 0;
    for (int i = 1; i <= 22; i++) begin
      cyc(1, 0, 2'd2);
      if (tk) begin
        ntick++;
        tick_idx = 6 * ntick;
        check1($sformatf("t6 tick%0d cycle", ntick), i, tick_idx);
      end
      if (i == 18) begin
        check1("t6 done", int'(done), 1);
        check1("t6 active", int'(act), 0);
        check1("t6 step", int'(sc), 3);
      end
    end
    check1("t6 tick count", ntick, 3);
    check1("t6 held step", int'(sc), 3);
    check1("t6 held idle", int'(act), 0);
    cyc(0, 0, 2'd2);
    check1("t6 done cleared", int'(done), 0);
    cyc(1, 0, 2'd2);
    check1("t6 restart active", int'(act), 1);
    step_limit = '0;
    reset = 1'b1;
    cyc(0, 0, 2'd0);
    reset = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
